fifo_upload_reader: RTL and testbench

- Read-side master for the capture FIFO storage.
- Once the capture side flags FIFO full, it drains bank A then bank B by driving the active-low read enables.
- Captures the 16-bit FIFO read data and presents it as a valid/ready word stream to the host upload path.
- Sits in the rclk domain, on the opposite end of the storage read port from the write/capture logic.

---
 rtl/fifo_upload_reader_pkg.sv | 17 +
 rtl/fifo_upload_reader_skid_buf.sv | 55 +++++
 rtl/fifo_upload_reader.sv | 155 +++++++++++++++
 tb/tb_fifo_upload_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_upload_reader_pkg.sv
// Shared types and default sizing for the capture-FIFO upload reader.
// Imported by the reader top and its output skid buffer.
package fifo_upload_reader_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_BANK_WORDS = 4096;
    localparam int unsigned DEF_CNT_W      = 13;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FULL,
        READ_A,
        READ_B,
        FLUSH
    } upl_state_t;

endpackage

// File: rtl/fifo_upload_reader_skid_buf.sv
// Two-entry valid/ready buffer between the FIFO read port and the host stream.
// The occupancy count is exported so the reader can throttle its read issue.
module upload_skid_buf
    import fifo_upload_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              rclk,
    input  logic              _mr,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push    = in_valid && (r_count != 2'd2);
    assign w_pop     = (r_count != 2'd0) && out_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge rclk or negedge _mr) begin
        if (!_mr) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/fifo_upload_reader.sv
// Read-side master for the capture FIFO: waits for the full flag, drains bank A
// then bank B, and streams the words to the host upload path.
module fifo_upload_reader
    import fifo_upload_reader_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned BANK_WORDS = DEF_BANK_WORDS,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              rclk,
    input  logic              _mr,
    input  logic              start,
    input  logic              abort,
    input  logic              ffa,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              _renA,
    output logic              _renB,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    upl_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ffa_s1;
    logic             r_ffa_s2;
    logic             r_rd_d;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_skid_count;
    logic             w_pop;
    logic [2:0]       w_load;
    logic             w_room;
    logic             w_rd_a;
    logic             w_rd_b;
    logic             w_abort;
    logic             w_last;
    logic             w_drained;

    always_ff @(posedge rclk or negedge _mr) begin
        if (!_mr) begin
            r_ffa_s1 <= 1'b0;
            r_ffa_s2 <= 1'b0;
        end else begin
            r_ffa_s1 <= ffa;
            r_ffa_s2 <= r_ffa_s1;
        end
    end

    // Credit counts the word already on fifo_dout plus buffered words, less the
    // one leaving this cycle, so a stream at full rate keeps one read per cycle.
    assign w_pop     = m_valid && m_ready;
    assign w_load    = 3'(r_rd_d) + 3'(w_skid_count) - 3'(w_pop);
    assign w_room    = (w_load < 3'd2);
    assign w_rd_a    = (r_state == READ_A) && w_room;
    assign w_rd_b    = (r_state == READ_B) && w_room;
    assign w_abort   = abort && (r_state != IDLE);
    assign w_last    = (r_cnt == CNT_W'(BANK_WORDS - 1));
    assign w_drained = !r_rd_d
                       && ((w_skid_count == 2'd0) || ((w_skid_count == 2'd1) && w_pop));

    assign _renA = ~w_rd_a;
    assign _renB = ~w_rd_b;
    assign busy  = r_busy;
    assign done  = r_done;

    // Marks that fifo_dout carries the word of last cycle's read; an abort drops it.
    always_ff @(posedge rclk or negedge _mr) begin
        if (!_mr) begin
            r_rd_d <= 1'b0;
        end else begin
            r_rd_d <= (w_rd_a || w_rd_b) && !w_abort;
        end
    end

    always_ff @(posedge rclk or negedge _mr) begin
        if (!_mr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state <= WAIT_FULL;
                            r_busy  <= 1'b1;
                        end
                    end
                    WAIT_FULL: begin
                        if (r_ffa_s2) begin
                            r_state <= READ_A;
                            r_cnt   <= '0;
                        end
                    end
                    READ_A: begin
                        if (w_rd_a) begin
                            if (w_last) begin
                                r_state <= READ_B;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    READ_B: begin
                        if (w_rd_b) begin
                            if (w_last) begin
                                r_state <= FLUSH;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    FLUSH: begin
                        if (w_drained) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    upload_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .rclk      (rclk),
        ._mr       (_mr),
        .clr       (w_abort),
        .in_valid  (r_rd_d),
        .in_data   (fifo_dout),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_ready (m_ready),
        .count     (w_skid_count)
    );

endmodule

// File: tb/tb_fifo_upload_reader.sv
// Bench for fifo_upload_reader with 8-word banks: FIFO storage model, ordered
// word scoreboard, scenario table plus hand-written abort/reset sequences.
module tb_fifo_upload_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    logic          rclk = 1'b0;
    logic          _mr = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ffa = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          _renA;
    logic          _renB;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          done;

    fifo_upload_reader #(
        .DATA_W     (DW),
        .BANK_WORDS (BW),
        .CNT_W      (4)
    ) dut (
        .rclk      (rclk),
        ._mr       (_mr),
        .start     (start),
        .abort     (abort),
        .ffa       (ffa),
        .fifo_dout (fifo_dout),
        ._renA     (_renA),
        ._renB     (_renB),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 rclk = ~rclk;

    // FIFO storage model: one-cycle read latency per bank.
    logic [DW-1:0] bank_a [BW];
    logic [DW-1:0] bank_b [BW];
    int            ptr_a = 0;
    int            ptr_b = 0;
    logic          fifo_rst = 1'b0;

    always @(posedge rclk) begin
        if (fifo_rst) begin
            ptr_a <= 0;
            ptr_b <= 0;
        end else if (!_renA) begin
            fifo_dout <= (ptr_a < int'(BW)) ? bank_a[ptr_a] : 16'hBAD0;
            ptr_a     <= ptr_a + 1;
        end else if (!_renB) begin
            fifo_dout <= (ptr_b < int'(BW)) ? bank_b[ptr_b] : 16'hBAD1;
            ptr_b     <= ptr_b + 1;
        end
    end

    typedef struct {
        logic [3:0] rdy_pat;
        int         ffa_dly;
        bit         dbl_start;
        bit         rnd;
        int         exp_words;
        int         exp_done;
    } vec_t;

    vec_t          vecs [6];
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q [$];
    int            gcyc = 0;
    int            issued, accepted, words_got, dones;
    int            a_cnt, a_first, a_last, b_cnt, b_first, b_last;
    int            last_acc_cyc;
    int            viol_both, viol_inflight;
    bit            prev_stall = 1'b0;
    bit            skip_stab = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, gcyc);
        end
    endtask

    task automatic load_banks(input bit rnd);
        for (int i = 0; i < int'(BW); i++) begin
            bank_a[i] = rnd ? 16'($urandom) : 16'(i);
            bank_b[i] = rnd ? 16'($urandom) : 16'(i + int'(BW));
        end
        exp_q.delete();
        for (int i = 0; i < int'(BW); i++) exp_q.push_back(bank_a[i]);
        for (int i = 0; i < int'(BW); i++) exp_q.push_back(bank_b[i]);
        issued = 0; accepted = 0; words_got = 0; dones = 0;
        a_cnt = 0; a_first = 0; a_last = 0; b_cnt = 0; b_first = 0; b_last = 0;
        last_acc_cyc = -10; viol_both = 0; viol_inflight = 0; prev_stall = 1'b0;
        fifo_rst = 1'b1;
        @(negedge rclk);
        fifo_rst = 1'b0;
    endtask

    // Observes one cycle just before its closing rising edge.
    task automatic sample();
        gcyc++;
        if (!_renA && !_renB) viol_both++;
        if (!_renA) begin
            if (a_cnt == 0) a_first = gcyc;
            a_last = gcyc; a_cnt++; issued++;
        end
        if (!_renB) begin
            if (b_cnt == 0) b_first = gcyc;
            b_last = gcyc; b_cnt++; issued++;
        end
        if (prev_stall && !skip_stab) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(prev_data));
        end
        skip_stab = 1'b0;
        if (m_valid && m_ready) begin
            accepted++; words_got++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_word: got %0h expected no word at cycle %0d", m_data, gcyc);
            end else begin
                check("word", 32'(m_data), 32'(exp_q.pop_front()));
            end
            last_acc_cyc = gcyc;
        end
        if (issued - accepted > 2) viol_inflight++;
        if (done) begin
            dones++;
            check("done_busy", 32'(busy), 32'd0);
            check("done_timing", 32'(gcyc), 32'(last_acc_cyc + 1));
            check("done_q_empty", 32'(exp_q.size()), 32'd0);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge rclk);
            start = 1'b0; abort = 1'b0; ffa = 1'b0;
        end
        prev_stall = 1'b0;
    endtask

    task automatic run_upload(input vec_t v);
        int  post;
        bit  dbl_done;
        post = 0; dbl_done = 1'b0;
        load_banks(v.rnd);
        for (int c = 0; c < 600; c++) begin
            @(negedge rclk);
            start = (c == 0);
            if (v.dbl_start && !dbl_done && a_cnt == 2) begin
                start = 1'b1; dbl_done = 1'b1;
            end
            ffa = (c >= v.ffa_dly);
            m_ready = v.rnd ? 1'($urandom_range(0, 1)) : v.rdy_pat[c % 4];
            #1 sample();
            if (dones > 0) post++;
            if (post >= 6) break;
        end
        check("words", 32'(words_got), 32'(v.exp_words));
        check("dones", 32'(dones), 32'(v.exp_done));
        check("both_en_low", 32'(viol_both), 32'd0);
        check("inflight_gt2", 32'(viol_inflight), 32'd0);
        check("a_reads", 32'(a_cnt), 32'(BW));
        check("b_reads", 32'(b_cnt), 32'(BW));
        if (v.rdy_pat == 4'hF && !v.rnd) begin
            check("a_burst_len", 32'(a_last - a_first), 32'(BW - 1));
            check("b_after_a", 32'(b_first), 32'(a_last + 1));
            check("b_burst_len", 32'(b_last - b_first), 32'(BW - 1));
        end
        idle(4);
    endtask

    initial begin
        int vb, ve, vv, ab_cyc;
        bit ab_done;
        vecs[0] = '{rdy_pat: 4'b1111, ffa_dly: 5, dbl_start: 1'b0, rnd: 1'b0, exp_words: 16, exp_done: 1};
        vecs[1] = '{rdy_pat: 4'b1001, ffa_dly: 5, dbl_start: 1'b0, rnd: 1'b0, exp_words: 16, exp_done: 1};
        vecs[2] = '{rdy_pat: 4'b1111, ffa_dly: 2, dbl_start: 1'b1, rnd: 1'b0, exp_words: 16, exp_done: 1};
        vecs[3] = '{rdy_pat: 4'b0110, ffa_dly: 3, dbl_start: 1'b0, rnd: 1'b0, exp_words: 16, exp_done: 1};
        vecs[4] = '{rdy_pat: 4'b0000, ffa_dly: 4, dbl_start: 1'b0, rnd: 1'b1, exp_words: 16, exp_done: 1};
        vecs[5] = '{rdy_pat: 4'b0000, ffa_dly: 1, dbl_start: 1'b1, rnd: 1'b1, exp_words: 16, exp_done: 1};

        #2 _mr = 1'b0;
        #1;
        check("rst_renA", 32'(_renA), 32'd1);
        check("rst_renB", 32'(_renB), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge rclk);
        _mr = 1'b1;
        idle(2);

        for (int i = 0; i < 6; i++) run_upload(vecs[i]);

        // No full flag: the reader parks in WAIT_FULL.
        vb = 0; ve = 0; vv = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge rclk);
            start = (c == 0); ffa = 1'b0; m_ready = 1'($urandom_range(0, 1));
            #1;
            if (c >= 1 && !busy) vb++;
            if (!_renA || !_renB) ve++;
            if (m_valid) vv++;
        end
        check("nofull_busy", 32'(vb), 32'd0);
        check("nofull_enables", 32'(ve), 32'd0);
        check("nofull_valid", 32'(vv), 32'd0);
        @(negedge rclk); start = 1'b0; abort = 1'b1;
        @(negedge rclk); abort = 1'b0;
        #1 check("nofull_abort_busy", 32'(busy), 32'd0);
        @(negedge rclk); abort = 1'b1;
        @(negedge rclk); abort = 1'b0;
        #1 check("idle_abort_busy", 32'(busy), 32'd0);
        @(negedge rclk); start = 1'b1; abort = 1'b1;
        @(negedge rclk); start = 1'b0; abort = 1'b0;
        #1 check("start_beats_abort", 32'(busy), 32'd1);
        @(negedge rclk); abort = 1'b1;
        @(negedge rclk); abort = 1'b0;
        #1 check("clear_busy", 32'(busy), 32'd0);
        idle(2);

        // Abort right after the third bank-A read.
        load_banks(1'b0);
        ab_done = 1'b0; ab_cyc = -100; vv = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge rclk);
            start = (c == 0); ffa = 1'b1; m_ready = 1'b1;
            abort = 1'b0;
            if (!ab_done && a_cnt == 3) begin
                abort = 1'b1; ab_done = 1'b1; ab_cyc = c; skip_stab = 1'b1;
            end
            #1 sample();
            if (c == ab_cyc + 1) begin
                check("abort_renA", 32'(_renA), 32'd1);
                check("abort_renB", 32'(_renB), 32'd1);
                check("abort_m_valid", 32'(m_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
            end
            if (ab_done && c > ab_cyc && (m_valid || !_renA || !_renB)) vv++;
            if (ab_done && c >= ab_cyc + 20) break;
        end
        abort = 1'b0;
        check("abort_reached", 32'(ab_done), 32'd1);
        check("abort_quiet_after", 32'(vv), 32'd0);
        check("abort_no_done", 32'(dones), 32'd0);
        idle(4);
        run_upload(vecs[0]);

        // Asynchronous reset while bank B is being read.
        load_banks(1'b1);
        for (int c = 0; c < 300 && b_cnt == 0; c++) begin
            @(negedge rclk);
            start = (c == 0); ffa = 1'b1; m_ready = 1'($urandom_range(0, 1));
            #1 sample();
        end
        check("reached_read_b", 32'(b_cnt != 0), 32'd1);
        @(posedge rclk);
        #2 _mr = 1'b0;
        #1;
        check("mr_renA", 32'(_renA), 32'd1);
        check("mr_renB", 32'(_renB), 32'd1);
        check("mr_m_valid", 32'(m_valid), 32'd0);
        check("mr_m_data", 32'(m_data), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        start = 1'b0;
        repeat (3) @(negedge rclk);
        _mr = 1'b1;
        vv = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge rclk);
            ffa = 1'b1; m_ready = 1'b1;
            #1;
            if (m_valid || busy || done || !_renA || !_renB) vv++;
        end
        check("mr_quiet_after", 32'(vv), 32'd0);
        idle(4);
        run_upload(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
